mc_bus_scheduler: RTL and testbench



---
 rtl/mc_bus_scheduler_pkg.sv | 24 ++
 rtl/mc_bus_scheduler_ack_collector.sv | 42 ++++
 rtl/mc_bus_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_mc_bus_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_bus_scheduler_pkg.sv
// Shared types for the multicaster bus scheduler: beat types, CASTER_EN
// bit positions and the scheduler FSM states.
package mc_bus_scheduler_pkg;

  typedef enum logic [1:0] {
    BEAT_IFMAP = 2'd0,
    BEAT_FLTR  = 2'd1,
    BEAT_PSUM  = 2'd2,
    BEAT_RSVD  = 2'd3
  } beat_type_e;

  localparam int CASTER_IFMAP = 0;
  localparam int CASTER_FLTR  = 1;
  localparam int CASTER_PSUM  = 2;
  localparam int CASTER_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_DELIVER = 2'd2,
    ST_DONE    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mc_bus_scheduler_ack_collector.sv
// Sticky per-column acknowledge collector. Loads the target mask when a beat
// goes onto the bus and reports when every target column has acknowledged,
// counting acks that arrive in the current cycle as well as earlier ones.
module mc_ack_collector
  import mc_bus_scheduler_pkg::*;
#(
  parameter int NUM_COL = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NUM_COL-1:0] i_mask,
  input  logic               i_active,
  input  logic               i_clear,
  input  logic [NUM_COL-1:0] i_mc_valid,
  output logic               o_all_acked
);

  logic [NUM_COL-1:0] r_mask;
  logic [NUM_COL-1:0] r_ack;
  logic [NUM_COL-1:0] w_hit;

  assign w_hit = i_mc_valid & r_mask;

  // Capture the target mask per beat and accumulate acks from target columns only
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask <= '0;
      r_ack  <= '0;
    end else if (i_load) begin
      r_mask <= i_mask;
      r_ack  <= '0;
    end else if (i_clear) begin
      r_ack <= '0;
    end else if (i_active) begin
      r_ack <= r_ack | w_hit;
    end
  end

  assign o_all_acked = ((r_ack | w_hit) == r_mask);

endmodule

// File: rtl/mc_bus_scheduler.sv
// Row-level bus scheduler for the multicasters: owns the column TAG table,
// accepts tagged ifmap/filter/psum beats and holds each one on the bus until
// all matching columns have acknowledged. Pulses done at the end of a pass.
module mc_bus_scheduler
  import mc_bus_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int CNT_W      = 16,
  localparam int TAG_W      = $clog2(NUM_COL)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_we,
  input  logic [TAG_W-1:0]         i_cfg_addr,
  input  logic [TAG_W-1:0]         i_cfg_tag,
  input  logic                     i_start,
  input  logic [CNT_W-1:0]         i_beat_total,
  input  logic [7:0]               i_kernel_size_in,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [1:0]               i_s_type,
  input  logic [TAG_W-1:0]         i_s_tag,
  input  logic [2*DATA_WIDTH-1:0]  i_s_data,
  output logic [DATA_WIDTH-1:0]    o_bus_ifmap,
  output logic [DATA_WIDTH-1:0]    o_bus_fltr,
  output logic [2*DATA_WIDTH-1:0]  o_bus_psum,
  output logic [CASTER_W-1:0]      o_bus_caster_en,
  output logic                     o_bus_ready,
  output logic [7:0]               o_bus_kernel_size,
  output logic [NUM_COL*TAG_W-1:0] o_col_id,
  output logic [NUM_COL*TAG_W-1:0] o_col_tag,
  input  logic [NUM_COL-1:0]       i_mc_valid,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  sched_state_e r_state;
  sched_state_e w_stateNext;

  logic [TAG_W-1:0]        r_tag [NUM_COL];
  logic [CNT_W-1:0]        r_beatTotal;
  logic [CNT_W-1:0]        r_beatCnt;
  logic [CNT_W-1:0]        r_dropCnt;
  logic [7:0]              r_kernelSize;
  logic [DATA_WIDTH-1:0]   r_busIfmap;
  logic [DATA_WIDTH-1:0]   r_busFltr;
  logic [2*DATA_WIDTH-1:0] r_busPsum;
  logic [CASTER_W-1:0]     r_casterEn;
  logic                    r_busReady;

  logic [NUM_COL-1:0]      w_mask;
  logic [CASTER_W-1:0]     w_casterOneHot;
  logic                    w_take;
  logic                    w_drop;
  logic                    w_send;
  logic                    w_allAcked;
  logic                    w_complete;
  logic                    w_lastBeat;
  logic                    w_startPass;

  assign w_take      = (r_state == ST_ACCEPT) && i_s_valid;
  assign w_drop      = w_take && ((w_mask == '0) || (i_s_type == BEAT_RSVD));
  assign w_send      = w_take && !w_drop;
  assign w_complete  = (r_state == ST_DELIVER) && w_allAcked;
  assign w_lastBeat  = ((r_beatCnt + CNT_W'(1)) == r_beatTotal);
  assign w_startPass = (r_state == ST_IDLE) && i_start && (i_beat_total != '0);

  // Column ids are fixed; the tag table is flattened onto the output bus
  always_comb begin
    o_col_id  = '0;
    o_col_tag = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      o_col_id[c*TAG_W +: TAG_W]  = TAG_W'(c);
      o_col_tag[c*TAG_W +: TAG_W] = r_tag[c];
    end
  end

  // Target mask of the offered beat and the one-hot caster enable for its type
  always_comb begin
    w_mask         = '0;
    w_casterOneHot = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      w_mask[c] = (r_tag[c] == i_s_tag);
    end
    case (beat_type_e'(i_s_type))
      BEAT_IFMAP: w_casterOneHot[CASTER_IFMAP] = 1'b1;
      BEAT_FLTR:  w_casterOneHot[CASTER_FLTR]  = 1'b1;
      BEAT_PSUM:  w_casterOneHot[CASTER_PSUM]  = 1'b1;
      BEAT_RSVD:  w_casterOneHot               = '0;
    endcase
  end

  mc_ack_collector #(
    .NUM_COL(NUM_COL)
  ) u_ack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_send),
    .i_mask      (w_mask),
    .i_active    (r_state == ST_DELIVER),
    .i_clear     (w_complete),
    .i_mc_valid  (i_mc_valid),
    .o_all_acked (w_allAcked)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state decode plus the state-derived handshake and status outputs
  always_comb begin
    w_stateNext = r_state;
    o_s_ready   = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_stateNext = (i_beat_total == '0) ? ST_DONE : ST_ACCEPT;
      end
      ST_ACCEPT: begin
        o_s_ready = 1'b1;
        if (w_drop)      w_stateNext = w_lastBeat ? ST_DONE : ST_ACCEPT;
        else if (w_send) w_stateNext = ST_DELIVER;
      end
      ST_DELIVER: begin
        if (w_allAcked) w_stateNext = w_lastBeat ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Tag table, pass counters and the registered bus fields
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_COL; c++) r_tag[c] <= TAG_W'(c);
      r_beatTotal  <= '0;
      r_beatCnt    <= '0;
      r_dropCnt    <= '0;
      r_kernelSize <= '0;
      r_busIfmap   <= '0;
      r_busFltr    <= '0;
      r_busPsum    <= '0;
      r_casterEn   <= '0;
      r_busReady   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && i_cfg_we) r_tag[i_cfg_addr] <= i_cfg_tag;
      if (w_startPass) begin
        r_beatTotal  <= i_beat_total;
        r_kernelSize <= i_kernel_size_in;
        r_beatCnt    <= '0;
        r_dropCnt    <= '0;
      end
      if (w_drop) begin
        r_beatCnt <= r_beatCnt + CNT_W'(1);
        if (r_dropCnt != '1) r_dropCnt <= r_dropCnt + CNT_W'(1);
      end
      if (w_send) begin
        r_busIfmap <= (i_s_type == BEAT_IFMAP) ? i_s_data[DATA_WIDTH-1:0] : '0;
        r_busFltr  <= (i_s_type == BEAT_FLTR)  ? i_s_data[DATA_WIDTH-1:0] : '0;
        r_busPsum  <= (i_s_type == BEAT_PSUM)  ? i_s_data : '0;
        r_casterEn <= w_casterOneHot;
        r_busReady <= 1'b1;
      end
      if (w_complete) begin
        r_casterEn <= '0;
        r_busReady <= 1'b0;
        r_beatCnt  <= r_beatCnt + CNT_W'(1);
      end
    end
  end

  assign o_bus_ifmap       = r_busIfmap;
  assign o_bus_fltr        = r_busFltr;
  assign o_bus_psum        = r_busPsum;
  assign o_bus_caster_en   = r_casterEn;
  assign o_bus_ready       = r_busReady;
  assign o_bus_kernel_size = r_kernelSize;
  assign o_drop_cnt        = r_dropCnt;

endmodule

// File: tb/tb_mc_bus_scheduler.sv
// Self-checking bench for mc_bus_scheduler: directed scenarios followed by
// randomized passes predicted by a beat-level model of the tag table,
// drop rule and sticky acknowledge rule.
module tb_mc_bus_scheduler;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int TW = 2;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfgWe;
  logic [TW-1:0]  cfgAddr;
  logic [TW-1:0]  cfgTag;
  logic           start;
  logic [CW-1:0]  beatTotal;
  logic [7:0]     kernelIn;
  logic           sValid;
  logic           sReady;
  logic [1:0]     sType;
  logic [TW-1:0]  sTag;
  logic [2*DW-1:0] sData;
  logic [DW-1:0]  busIfmap;
  logic [DW-1:0]  busFltr;
  logic [2*DW-1:0] busPsum;
  logic [2:0]     busCasterEn;
  logic           busReady;
  logic [7:0]     busKernel;
  logic [NC*TW-1:0] colId;
  logic [NC*TW-1:0] colTag;
  logic [NC-1:0]  mcValid;
  logic           busy;
  logic           done;
  logic [CW-1:0]  dropCnt;

  int checks = 0;
  int errors = 0;
  int mTag [NC];
  logic [3:0] ackSeq [5] = '{4'h1, 4'h8, 4'h4, 4'h8, 4'h2};
  int pulses;
  int cycles;

  mc_bus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr),
    .i_cfg_tag(cfgTag), .i_start(start), .i_beat_total(beatTotal),
    .i_kernel_size_in(kernelIn), .i_s_valid(sValid), .o_s_ready(sReady),
    .i_s_type(sType), .i_s_tag(sTag), .i_s_data(sData),
    .o_bus_ifmap(busIfmap), .o_bus_fltr(busFltr), .o_bus_psum(busPsum),
    .o_bus_caster_en(busCasterEn), .o_bus_ready(busReady),
    .o_bus_kernel_size(busKernel), .o_col_id(colId), .o_col_tag(colTag),
    .i_mc_valid(mcValid), .o_busy(busy), .o_done(done), .o_drop_cnt(dropCnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ty, input logic [1:0] tg,
                               input logic [31:0] d, input logic [3:0] mv);
    sValid  = v;
    sType   = ty;
    sTag    = tg;
    sData   = d;
    mcValid = mv;
  endtask

  function automatic logic [7:0] packTags();
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*TW +: TW] = 2'(mTag[c]);
    return v;
  endfunction

  function automatic logic [3:0] targetMask(input int tg);
    logic [3:0] m;
    m = '0;
    for (int c = 0; c < NC; c++) m[c] = (mTag[c] == tg);
    return m;
  endfunction

  task automatic writeTag(input int col, input int tg);
    cfgWe   = 1'b1;
    cfgAddr = 2'(col);
    cfgTag  = 2'(tg);
    step();
    cfgWe   = 1'b0;
    mTag[col] = tg;
  endtask

  task automatic startPass(input int total, input logic [7:0] ks);
    start     = 1'b1;
    beatTotal = 16'(total);
    kernelIn  = ks;
    step();
    start     = 1'b0;
  endtask

  // One pass predicted beat by beat from the model tag table
  task automatic runPass(input int total, input bit stuck, input bit allowDrops,
                         input string name, output int nPulses, output int nCycles);
    int beats, drops, cyc, waitCyc, col;
    logic v;
    logic [1:0] ty, tg;
    logic [31:0] d;
    logic [3:0] mask, pending, mv;
    logic [7:0] ks;
    bit delivered;
    beats = 0; drops = 0; cyc = 0; nPulses = 0;
    ks = 8'($urandom_range(1, 255));
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, stuck ? 4'hF : 4'h0);
    startPass(total, ks);
    while (beats < total && cyc < 2000) begin
      checkOutput({name, " s_ready accept"}, 64'(sReady), 64'd1);
      v  = stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
      ty = allowDrops ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      if (allowDrops) tg = 2'($urandom_range(0, 3));
      else begin
        col = $urandom_range(0, NC - 1);
        tg  = 2'(mTag[col]);
      end
      d = $urandom;
      applyStimulus(v, ty, tg, d, stuck ? 4'hF : 4'h0);
      mask = targetMask(int'(tg));
      step(); cyc++;
      if (!v) begin
        checkOutput({name, " idle bus_ready"}, 64'(busReady), 64'd0);
        continue;
      end
      if (mask == 4'h0 || ty == 2'd3) begin
        drops++; beats++;
        checkOutput({name, " drop bus_ready"}, 64'(busReady), 64'd0);
        continue;
      end
      pending = mask; delivered = 1'b0; waitCyc = 0;
      while (!delivered && cyc < 2000) begin
        checkOutput({name, " bus_ready"}, 64'(busReady), 64'd1);
        checkOutput({name, " caster_en"}, 64'(busCasterEn), 64'(3'b001 << ty));
        checkOutput({name, " ifmap"}, 64'(busIfmap), (ty == 2'd0) ? 64'(d[15:0]) : 64'd0);
        checkOutput({name, " fltr"},  64'(busFltr),  (ty == 2'd1) ? 64'(d[15:0]) : 64'd0);
        checkOutput({name, " psum"},  64'(busPsum),  (ty == 2'd2) ? 64'(d) : 64'd0);
        checkOutput({name, " s_ready deliver"}, 64'(sReady), 64'd0);
        mv = (stuck || waitCyc > 20) ? 4'hF : 4'($urandom_range(0, 15));
        mcValid = mv;
        step(); cyc++; waitCyc++;
        pending = pending & ~mv;
        if (pending == 4'h0) begin
          delivered = 1'b1; beats++; nPulses++;
          checkOutput({name, " released bus_ready"}, 64'(busReady), 64'd0);
          checkOutput({name, " released caster"}, 64'(busCasterEn), 64'd0);
        end
      end
      mcValid = stuck ? 4'hF : 4'h0;
    end
    nCycles = cyc;
    checkOutput({name, " done"}, 64'(done), 64'd1);
    checkOutput({name, " drop_cnt"}, 64'(dropCnt), 64'(drops));
    checkOutput({name, " kernel"}, 64'(busKernel), 64'(ks));
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    step();
    checkOutput({name, " done cleared"}, 64'(done), 64'd0);
    checkOutput({name, " idle busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgTag = '0; start = 1'b0;
    beatTotal = '0; kernelIn = '0;
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    for (int c = 0; c < NC; c++) mTag[c] = c;
    step(); step();

    $display("[TB] reset state");
    checkOutput("rst col_tag", 64'(colTag), 64'h00E4);
    checkOutput("rst col_id", 64'(colId), 64'h00E4);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst bus_ready", 64'(busReady), 64'd0);
    checkOutput("rst caster", 64'(busCasterEn), 64'd0);
    checkOutput("rst ifmap", 64'(busIfmap), 64'd0);
    checkOutput("rst fltr", 64'(busFltr), 64'd0);
    checkOutput("rst psum", 64'(busPsum), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkOutput("rst drop_cnt", 64'(dropCnt), 64'd0);
    checkOutput("rst kernel", 64'(busKernel), 64'd0);
    checkOutput("rst s_ready", 64'(sReady), 64'd0);
    rst = 1'b0;
    step();

    $display("[TB] empty pass");
    applyStimulus(1'b1, 2'd0, 2'd0, 32'h1, 4'h0);
    startPass(0, 8'd9);
    checkOutput("empty done", 64'(done), 64'd1);
    checkOutput("empty s_ready", 64'(sReady), 64'd0);
    step();
    checkOutput("empty done cleared", 64'(done), 64'd0);
    checkOutput("empty busy", 64'(busy), 64'd0);
    checkOutput("empty kernel", 64'(busKernel), 64'd0);
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);

    $display("[TB] unicast ifmap beat");
    startPass(1, 8'd3);
    checkOutput("uni s_ready", 64'(sReady), 64'd1);
    applyStimulus(1'b1, 2'd0, 2'd2, 32'h0000_00AB, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    checkOutput("uni bus_ready", 64'(busReady), 64'd1);
    checkOutput("uni caster", 64'(busCasterEn), 64'd1);
    checkOutput("uni ifmap", 64'(busIfmap), 64'h00AB);
    checkOutput("uni kernel", 64'(busKernel), 64'd3);
    mcValid = 4'b0100;
    step();
    mcValid = 4'h0;
    checkOutput("uni done", 64'(done), 64'd1);
    checkOutput("uni drop_cnt", 64'(dropCnt), 64'd0);
    step();

    $display("[TB] multicast psum with staggered acks");
    writeTag(0, 1); writeTag(1, 1); writeTag(2, 1); writeTag(3, 0);
    checkOutput("mc col_tag", 64'(colTag), 64'h0015);
    startPass(1, 8'd5);
    applyStimulus(1'b1, 2'd2, 2'd1, 32'h1234_5678, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    checkOutput("mc caster", 64'(busCasterEn), 64'd4);
    checkOutput("mc ifmap zero", 64'(busIfmap), 64'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mc held bus_ready", 64'(busReady), 64'd1);
      checkOutput("mc held psum", 64'(busPsum), 64'h1234_5678);
      mcValid = ackSeq[i];
      step();
    end
    mcValid = 4'h0;
    checkOutput("mc released", 64'(busReady), 64'd0);
    checkOutput("mc done", 64'(done), 64'd1);
    step();

    $display("[TB] dropped beats");
    writeTag(3, 1);
    checkOutput("drop col_tag", 64'(colTag), 64'h0055);
    startPass(3, 8'd7);
    applyStimulus(1'b1, 2'd0, 2'd3, 32'h0000_1111, 4'h0);
    step();
    checkOutput("drop1 s_ready", 64'(sReady), 64'd1);
    checkOutput("drop1 cnt", 64'(dropCnt), 64'd1);
    checkOutput("drop1 bus_ready", 64'(busReady), 64'd0);
    applyStimulus(1'b1, 2'd1, 2'd1, 32'h0000_5A5A, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'hF);
    checkOutput("drop fltr", 64'(busFltr), 64'h5A5A);
    checkOutput("drop caster", 64'(busCasterEn), 64'd2);
    checkOutput("drop psum zero", 64'(busPsum), 64'd0);
    step();
    checkOutput("drop back to accept", 64'(sReady), 64'd1);
    checkOutput("drop no early done", 64'(done), 64'd0);
    applyStimulus(1'b1, 2'd3, 2'd1, 32'h0000_2222, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    checkOutput("drop last done", 64'(done), 64'd1);
    checkOutput("drop2 cnt", 64'(dropCnt), 64'd2);
    step();
    checkOutput("drop cnt holds", 64'(dropCnt), 64'd2);

    $display("[TB] cfg and start ignored while busy");
    startPass(1, 8'd2);
    checkOutput("busy drop cleared", 64'(dropCnt), 64'd0);
    cfgWe = 1'b1; cfgAddr = 2'd0; cfgTag = 2'd3; start = 1'b1; beatTotal = 16'd5;
    applyStimulus(1'b1, 2'd0, 2'd1, 32'h0000_0077, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    checkOutput("busy col_tag accept", 64'(colTag), 64'h0055);
    step();
    checkOutput("busy col_tag deliver", 64'(colTag), 64'h0055);
    checkOutput("busy still delivering", 64'(busReady), 64'd1);
    mcValid = 4'hF;
    step();
    cfgWe = 1'b0; start = 1'b0; mcValid = 4'h0;
    checkOutput("busy single beat done", 64'(done), 64'd1);
    step();
    checkOutput("busy back idle", 64'(busy), 64'd0);

    $display("[TB] reset during deliver");
    startPass(2, 8'd4);
    applyStimulus(1'b1, 2'd2, 2'd1, 32'hCAFE_0001, 4'h0);
    step();
    applyStimulus(1'b0, 2'd0, 2'd0, 32'd0, 4'h0);
    checkOutput("rstmid bus_ready before", 64'(busReady), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) mTag[c] = c;
    checkOutput("rstmid bus_ready", 64'(busReady), 64'd0);
    checkOutput("rstmid psum", 64'(busPsum), 64'd0);
    checkOutput("rstmid col_tag", 64'(colTag), 64'(packTags()));
    checkOutput("rstmid done", 64'(done), 64'd0);
    checkOutput("rstmid busy", 64'(busy), 64'd0);
    step();
    checkOutput("rstmid no done", 64'(done), 64'd0);

    $display("[TB] back-to-back beats, acks stuck high");
    runPass(4, 1'b1, 1'b0, "stuck", pulses, cycles);
    checkOutput("stuck pulses", 64'(pulses), 64'd4);
    checkOutput("stuck cycles to done", 64'(cycles), 64'd8);

    $display("[TB] randomized passes");
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < NC; c++) writeTag(c, $urandom_range(0, 3));
      checkOutput("rand col_tag", 64'(colTag), 64'(packTags()));
      runPass(12 + p, 1'b0, 1'b1, "rand", pulses, cycles);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
